alu_issue_queue: RTL and testbench
==================================

// Module: alu_issue_queue
// PURPOSE
//  Command buffer and result-capture stage around the 2-bit-opcode 4-bit ALU (and/or/sub/add).
//  Accepts {code,a,b} commands over valid/ready and queues them in a FIFO.
//  Drives the FIFO head onto the combinational ALU inputs.
//  Registers the 5-bit ALU result with its opcode, then presents it downstream over valid/ready.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of 2, >=2
//  AW      2   pointer width; AW = log2(DEPTH)
// PORTS
//  clk        in   1   single clock, rising edge
//  reset      in   1   asynchronous, active-high; clears all state
//  in_valid   in   1   command present
//  in_ready   out  1   queue can accept (= !full)
//  in_code    in   2   opcode 00 and, 01 or, 10 sub, 11 add
//  in_a       in   4   operand a
//  in_b       in   4   operand b
//  alu_code   out  2   head opcode to ALU (0 when empty)
//  alu_a      out  4   head operand a to ALU (0 when empty)
//  alu_b      out  4   head operand b to ALU (0 when empty)
//  alu_c      in   5   combinational ALU result for current alu_* inputs
//  out_valid  out  1   result register holds a result
//  out_ready  in   1   downstream accepts result
//  out_code   out  2   opcode of held result
//  out_data   out  5   held result
//  level      out  AW+1 FIFO occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset (async, any cycle): in_ready=1, out_valid=0, out_code=0, out_data=0, level=0,
//   rd/wr pointers=0. A command in flight is discarded.
//  Push: in_valid && in_ready at a rising edge writes {in_code,in_a,in_b} at wr_ptr.
//   wr_ptr wraps DEPTH-1 -> 0.
//  Full (level==DEPTH): in_ready=0; in_valid is ignored; no bypass.
//  alu_* is driven combinationally from the head entry; it is forced to 0 when level==0.
//  Pop condition: level!=0 && (!out_valid || out_ready).
//   On pop: out_data<=alu_c, out_code<=head code, out_valid<=1, rd_ptr++ (wraps).
//  Drain: out_valid && out_ready with no pop -> out_valid<=0.
//   out_data and out_code hold their last values.
//  Stall: out_valid && !out_ready -> out_data and out_code are held; no pop.
//  Latency: a push at edge N is popped at edge N+1 at the earliest (FIFO was empty, output free).
//   out_valid is high after edge N+1. Throughput is 1 result per cycle.
//  Push and pop in the same cycle: level is unchanged.
//   Pop uses occupancy at the start of the cycle, so a command pushed into an empty FIFO
//   cannot pop in the same edge.
//  Arithmetic, captured exactly as the ALU supplies it:
//   sub: 5-bit two's-complement wrap, e.g. 3-5 = 5'h1E.
//   add: carry in bit 4, e.g. F+F = 5'h1E.
//   and/or: bit 4 = 0.
//  level increments on push only, decrements on pop only; it never exceeds DEPTH
//   and never underflows.
//  FIFO storage needs no reset. Only pointers, level and output registers are reset.
// CONFIGURATION
//  ALU_ISSUE_CNT_EN defined:
//   adds port cmd_cnt out 8: count of pops since reset.
//   Wraps 255 -> 0. Reset value 0. Increments on the same edge as out_valid is set by a pop.
//  ALU_ISSUE_CNT_EN undefined: no cmd_cnt port and no counter logic.
// TESTING
//  1. Reset mid-stream with level=3 and out_valid=1, then release
//     -> in_ready=1, level=0, out_valid=0, out_data=0 immediately (async, before next edge).
//  2. Push {00,A,6}, out_ready=1 -> next edge out_valid=1, out_code=00, out_data=5'h02.
//  3. Push {10,3,5} then {11,F,F}, out_ready=1
//     -> results 5'h1E (code 10), then 5'h1E (code 11), on consecutive cycles.
//  4. Hold out_ready=0 and push 5 commands -> first captured, next 4 fill FIFO,
//     level=4, in_ready=0, 6th push ignored.
//     Then out_ready=1 -> results in order, one per cycle.
//  5. Simultaneous push and pop at level=2 over 10 cycles
//     -> level stays 2, pointers wrap, results in order.
//  6. With ALU_ISSUE_CNT_EN, 257 commands -> cmd_cnt=1.
//     Without the macro the bench builds with no cmd_cnt port.

Source files
------------

// File: rtl/alu_issue_queue.sv
// Command FIFO feeding an external combinational ALU, with a registered valid/ready result stage.
// Optional ALU_ISSUE_CNT_EN adds an 8-bit cmd_cnt output counting pops since reset.
module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_code,
  input  logic [3:0]    in_a,
  input  logic [3:0]    in_b,
  output logic [1:0]    alu_code,
  output logic [3:0]    alu_a,
  output logic [3:0]    alu_b,
  input  logic [4:0]    alu_c,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    out_code,
  output logic [4:0]    out_data,
  output logic [AW:0]   level
`ifdef ALU_ISSUE_CNT_EN
  ,
  output logic [7:0]    cmd_cnt
`endif
);

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [9:0]    head;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  assign empty    = (level == '0);
  assign full     = (level == (AW+1)'(DEPTH));
  assign in_ready = !full;
  assign push     = in_valid && !full;
  // pop decision uses start-of-cycle occupancy, so a fresh push never pops on the same edge
  assign pop      = !empty && (!out_valid || out_ready);
  assign head     = mem[rd_ptr];

  always_comb begin
    alu_code = '0;
    alu_a    = '0;
    alu_b    = '0;
    if (!empty) begin
      alu_code = head[9:8];
      alu_a    = head[7:4];
      alu_b    = head[3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_code, in_a, in_b};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_code  <= '0;
      out_data  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        out_valid <= 1'b1;
        out_code  <= head[9:8];
        out_data  <= alu_c;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

`ifdef ALU_ISSUE_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    cmd_cnt <= '0;
    else if (pop) cmd_cnt <= cmd_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: queue-based reference model checked every cycle plus directed literals.
// Exercises cmd_cnt when ALU_ISSUE_CNT_EN is defined.
module tb_alu_issue_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_code;
  logic [3:0]    in_a;
  logic [3:0]    in_b;
  logic [1:0]    alu_code;
  logic [3:0]    alu_a;
  logic [3:0]    alu_b;
  logic [4:0]    alu_c;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_code;
  logic [4:0]    out_data;
  logic [AW:0]   level;
`ifdef ALU_ISSUE_CNT_EN
  logic [7:0]    cmd_cnt;
`endif

  int errors = 0;
  int checks = 0;

  alu_issue_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_a(in_a), .in_b(in_b),
    .alu_code(alu_code), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .out_data(out_data),
    .level(level)
`ifdef ALU_ISSUE_CNT_EN
    , .cmd_cnt(cmd_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Environment ALU: gate-style formulation feeding alu_c
  function automatic logic [4:0] env_alu(logic [1:0] c, logic [3:0] a, logic [3:0] b);
    case (c)
      2'b00:   return {1'b0, a & b};
      2'b01:   return {1'b0, a | b};
      2'b10:   return {1'b0, a} + {1'b1, ~b} + 5'd1;
      default: return {1'b0, a} + {1'b0, b};
    endcase
  endfunction

  assign alu_c = env_alu(alu_code, alu_a, alu_b);

  // Reference arithmetic from integer math
  function automatic logic [4:0] ref_result(logic [9:0] cmd);
    int a, b, r;
    a = int'(cmd[7:4]);
    b = int'(cmd[3:0]);
    case (cmd[9:8])
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = (a - b + 32) % 32;
      default: r = (a + b) % 32;
    endcase
    return r[4:0];
  endfunction

  logic [9:0] q[$];
  logic       m_valid = 1'b0;
  logic [1:0] m_code  = '0;
  logic [4:0] m_data  = '0;
  int         m_cnt   = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_valid = 1'b0;
      m_code  = '0;
      m_data  = '0;
      m_cnt   = 0;
    end else begin
      automatic bit was_full = (q.size() == DEPTH);
      if (q.size() != 0 && (!m_valid || out_ready)) begin
        m_data  = ref_result(q[0]);
        m_code  = q[0][9:8];
        m_valid = 1'b1;
        m_cnt   = (m_cnt + 1) % 256;
        void'(q.pop_front());
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      if (in_valid && !was_full) q.push_back({in_code, in_a, in_b});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    automatic logic [9:0] hd = (q.size() != 0) ? q[0] : 10'd0;
    chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    chk("level", 32'(level), 32'(q.size()));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_code", 32'(out_code), 32'(m_code));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("alu_code", 32'(alu_code), 32'(hd[9:8]));
    chk("alu_a", 32'(alu_a), 32'(hd[7:4]));
    chk("alu_b", 32'(alu_b), 32'(hd[3:0]));
`ifdef ALU_ISSUE_CNT_EN
    chk("cmd_cnt", 32'(cmd_cnt), 32'(m_cnt));
`endif
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] c, input logic [3:0] a, input logic [3:0] b);
    in_valid = v;
    in_code  = c;
    in_a     = a;
    in_b     = b;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 2'b00, 4'h0, 4'h0);
    out_ready = 1'b0;
    cyc();
    cyc();
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    cyc();

    // and: A & 6 = 2, visible one edge after the push
    out_ready = 1'b1;
    drive(1'b1, 2'b00, 4'hA, 4'h6);
    cyc();
    drive(1'b0, 2'b00, 4'h0, 4'h0);
    chk("t2_not_yet", 32'(out_valid), 32'd0);
    cyc();
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_code", 32'(out_code), 32'd0);
    chk("t2_data", 32'(out_data), 32'h02);

    // sub wrap 3-5 and add carry F+F on consecutive cycles
    drive(1'b1, 2'b10, 4'h3, 4'h5);
    cyc();
    drive(1'b1, 2'b11, 4'hF, 4'hF);
    cyc();
    drive(1'b0, 2'b00, 4'h0, 4'h0);
    chk("t3_sub_code", 32'(out_code), 32'd2);
    chk("t3_sub_data", 32'(out_data), 32'h1E);
    cyc();
    chk("t3_add_code", 32'(out_code), 32'd3);
    chk("t3_add_data", 32'(out_data), 32'h1E);
    chk("t3_add_valid", 32'(out_valid), 32'd1);
    cyc();
    cyc();
    chk("t3_drained", 32'(out_valid), 32'd0);
    chk("t3_hold_data", 32'(out_data), 32'h1E);

    // stall output, fill the FIFO, sixth push must be dropped
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, 2'b01, 4'(k), 4'h8);
      cyc();
    end
    drive(1'b0, 2'b00, 4'h0, 4'h0);
    chk("t4_level_full", 32'(level), 32'd4);
    chk("t4_in_ready", 32'(in_ready), 32'd0);
    chk("t4_held_data", 32'(out_data), 32'h09);
    cyc();
    chk("t4_still_held", 32'(out_data), 32'h09);
    out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      cyc();
      chk("t4_order", 32'(out_data), 32'(k | 8));
    end
    cyc();
    chk("t4_empty", 32'(out_valid), 32'd0);

    // steady push+pop at level 2 across pointer wrap
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 2'b11, 4'(k), 4'(k + 3));
      cyc();
    end
    chk("t5_level_start", 32'(level), 32'd2);
    out_ready = 1'b1;
    for (int k = 3; k < 13; k++) begin
      drive(1'b1, 2'b11, 4'(k), 4'(k + 3));
      cyc();
      chk("t5_level", 32'(level), 32'd2);
    end
    drive(1'b0, 2'b00, 4'h0, 4'h0);
    repeat (4) cyc();
    chk("t5_drained_level", 32'(level), 32'd0);

    // asynchronous reset with level 3 and a held result
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'b11, 4'hF, 4'(k));
      cyc();
    end
    drive(1'b0, 2'b00, 4'h0, 4'h0);
    chk("t1_pre_level", 32'(level), 32'd3);
    chk("t1_pre_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t1_in_ready", 32'(in_ready), 32'd1);
    chk("t1_level", 32'(level), 32'd0);
    chk("t1_out_valid", 32'(out_valid), 32'd0);
    chk("t1_out_data", 32'(out_data), 32'd0);
    cyc();
    reset = 1'b0;
    cyc();

`ifdef ALU_ISSUE_CNT_EN
    out_ready = 1'b1;
    for (int k = 0; k < 257; k++) begin
      drive(1'b1, 2'(k), 4'(k), 4'(k >> 4));
      cyc();
    end
    drive(1'b0, 2'b00, 4'h0, 4'h0);
    repeat (4) cyc();
    chk("t6_cmd_cnt", 32'(cmd_cnt), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule
